// File: rtl/f_minmax_pipe.sv
// Pipelined IEEE-754 FMIN/FMAX with RISC-V NaN semantics on native encodings.
// A shift chain of LATENCY slots moves as one; the tag rides along for writeback routing.
module f_minmax_pipe #(
  parameter int EXP_W   = 8,
  parameter int MANT_W  = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 5,
  localparam int FLEN   = 1 + EXP_W + MANT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              op_max,
  input  logic [FLEN-1:0]   a,
  input  logic [FLEN-1:0]   b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FLEN-1:0]   res,
  output logic              flag_nv,
  output logic [TAG_W-1:0]  out_tag
);

  localparam logic [FLEN-1:0] CANON_NAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MANT_W-1){1'b0}}};

  typedef struct packed {
    logic [FLEN-1:0]  a;
    logic [FLEN-1:0]  b;
    logic             op_max;
    logic [TAG_W-1:0] tag;
    logic             a_nan;
    logic             b_nan;
    logic             nv;
    logic             mag_gt;
    logic             mag_eq;
  } stage_t;

  // Handshake: a transfer happens on a rising edge where valid && ready. The whole
  // chain advances when the output slot is empty or being drained, so in_ready is
  // purely !out_valid || out_ready and never looks at in_valid.
  logic   advance;
  logic   accept;
  stage_t c_p;
  stage_t m_p;
  logic   m_valid;
  logic   f_valid;

  assign advance   = !out_valid || out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid && advance;
  assign out_valid = f_valid;

  function automatic logic is_nan(input logic [FLEN-1:0] x);
    return (&x[FLEN-2:MANT_W]) && (|x[MANT_W-1:0]);
  endfunction

  function automatic logic [FLEN-1:0] pick(input stage_t p);
    logic a_lt;
    if (p.a[FLEN-1] != p.b[FLEN-1])
      a_lt = p.a[FLEN-1];
    else if (p.a[FLEN-1])
      a_lt = p.mag_gt;
    else
      a_lt = !p.mag_gt && !p.mag_eq;
    if (p.a_nan && p.b_nan)
      return CANON_NAN;
    else if (p.a_nan)
      return p.b;
    else if (p.b_nan)
      return p.a;
    else
      return (p.op_max ^ a_lt) ? p.a : p.b;
  endfunction

  always_comb begin
    c_p        = '0;
    c_p.a      = a;
    c_p.b      = b;
    c_p.op_max = op_max;
    c_p.tag    = in_tag;
    c_p.a_nan  = is_nan(a);
    c_p.b_nan  = is_nan(b);
    c_p.nv     = (is_nan(a) && !a[MANT_W-1]) || (is_nan(b) && !b[MANT_W-1]);
    c_p.mag_gt = a[FLEN-2:0] > b[FLEN-2:0];
    c_p.mag_eq = a[FLEN-2:0] == b[FLEN-2:0];
  end

  generate
    if (LATENCY == 1) begin : g_merged
      assign m_valid = accept;
      assign m_p     = c_p;
    end else begin : g_split
      logic   s1_valid;
      stage_t s1_p;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_valid <= 1'b0;
          s1_p     <= '0;
        end else if (advance) begin
          s1_valid <= accept;
          if (accept) s1_p <= c_p;
        end
      end

      if (LATENCY >= 3) begin : g_retime
        logic   s2_valid;
        stage_t s2_p;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_p     <= '0;
          end else if (advance) begin
            s2_valid <= s1_valid;
            if (s1_valid) s2_p <= s1_p;
          end
        end

        assign m_valid = s2_valid;
        assign m_p     = s2_p;
      end else begin : g_direct
        assign m_valid = s1_valid;
        assign m_p     = s1_p;
      end
    end
  endgenerate

  // Final slot: outputs come straight from these registers and hold during a stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f_valid <= 1'b0;
      res     <= '0;
      flag_nv <= 1'b0;
      out_tag <= '0;
    end else if (advance) begin
      f_valid <= m_valid;
      if (m_valid) begin
        res     <= pick(m_p);
        flag_nv <= m_p.nv;
        out_tag <= m_p.tag;
      end
    end
  end

endmodule

// File: tb/tb_f_minmax_pipe.sv
// Bench for f_minmax_pipe: single precision at LATENCY=2 with a scoreboard,
// plus a double precision LATENCY=3 instance driven one operation at a time.
module tb_f_minmax_pipe;

  localparam int LAT0 = 2;
  localparam int LAT1 = 3;
  localparam int W    = 32 + 1 + 5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        op_max = 1'b0;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] res;
  logic        flag_nv;
  logic [4:0]  out_tag;

  logic        d_in_valid = 1'b0;
  logic        d_in_ready;
  logic        d_op_max = 1'b0;
  logic [63:0] d_a = '0;
  logic [63:0] d_b = '0;
  logic [4:0]  d_in_tag = '0;
  logic        d_out_valid;
  logic        d_out_ready = 1'b1;
  logic [63:0] d_res;
  logic        d_flag_nv;
  logic [4:0]  d_out_tag;

  int n_checks = 0;
  int n_pass   = 0;
  int n_in     = 0;
  int n_out    = 0;

  logic [W-1:0] exp_q[$];

  f_minmax_pipe #(.EXP_W(8), .MANT_W(23), .LATENCY(LAT0), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .op_max(op_max),
    .a(in_a), .b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .flag_nv(flag_nv), .out_tag(out_tag)
  );

  f_minmax_pipe #(.EXP_W(11), .MANT_W(52), .LATENCY(LAT1), .TAG_W(5)) dut_d (
    .clk(clk), .rst_n(rst_n),
    .in_valid(d_in_valid), .in_ready(d_in_ready), .op_max(d_op_max),
    .a(d_a), .b(d_b), .in_tag(d_in_tag),
    .out_valid(d_out_valid), .out_ready(d_out_ready),
    .res(d_res), .flag_nv(d_flag_nv), .out_tag(d_out_tag)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: IEEE min/max from the field-level rules, any width up to 64 bits.
  function automatic void model(input logic [63:0] x, input logic [63:0] y, input logic is_max,
                                input int ew, input int mw,
                                output logic [63:0] r, output logic nv);
    logic [63:0] emask, mmask, magmask, canon, mag_x, mag_y;
    logic sx, sy, nan_x, nan_y, snan_x, snan_y, x_less;
    emask   = (64'd1 << ew) - 1;
    mmask   = (64'd1 << mw) - 1;
    magmask = (64'd1 << (ew + mw)) - 1;
    canon   = (emask << mw) | (64'd1 << (mw - 1));
    sx      = x[ew+mw];
    sy      = y[ew+mw];
    nan_x   = (((x >> mw) & emask) == emask) && ((x & mmask) != 0);
    nan_y   = (((y >> mw) & emask) == emask) && ((y & mmask) != 0);
    snan_x  = nan_x && !x[mw-1];
    snan_y  = nan_y && !y[mw-1];
    mag_x   = x & magmask;
    mag_y   = y & magmask;
    if (x == y)        x_less = 1'b0;
    else if (sx != sy) x_less = sx;
    else if (!sx)      x_less = mag_x < mag_y;
    else               x_less = mag_x > mag_y;
    nv = snan_x || snan_y;
    if (nan_x && nan_y) r = canon;
    else if (nan_x)     r = y;
    else if (nan_y)     r = x;
    else if (is_max)    r = x_less ? y : x;
    else                r = x_less ? x : y;
  endfunction

  function automatic logic [63:0] rand_fp(input int ew, input int mw);
    logic [63:0] full, emask, lo, v;
    logic s;
    full  = ~64'd0 >> (63 - ew - mw);
    emask = (64'd1 << ew) - 1;
    lo    = {$urandom(), $urandom()} & ((64'd1 << (mw - 1)) - 1);
    s     = 1'($urandom_range(0, 1));
    case ($urandom_range(0, 7))
      3:       v = 64'(s) << (ew + mw);
      4:       v = (64'(s) << (ew + mw)) | (emask << mw);
      5:       v = (64'(s) << (ew + mw)) | (emask << mw) | (64'd1 << (mw - 1)) | lo;
      6:       v = (64'(s) << (ew + mw)) | (emask << mw) | ((lo == 0) ? 64'd1 : lo);
      default: v = {$urandom(), $urandom()} & full;
    endcase
    return v;
  endfunction

  // scoreboard / compare process for the single-precision instance
  logic        prev_stall = 1'b0;
  logic [31:0] prev_res;
  logic        prev_nv;
  logic [4:0]  prev_tag;

  always @(negedge clk) begin
    logic [W-1:0] e;
    logic [63:0]  r;
    logic         nv;
    if (!rst_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", in_ready, !out_valid || out_ready);
      if (prev_stall) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_res", res, prev_res);
        chk("stall_nv", flag_nv, prev_nv);
        chk("stall_tag", out_tag, prev_tag);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("sb_res", res, e[W-1:6]);
          chk("sb_nv", flag_nv, e[5]);
          chk("sb_tag", out_tag, e[4:0]);
        end
        n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_res   = res;
      prev_nv    = flag_nv;
      prev_tag   = out_tag;
      if (in_valid && in_ready) begin
        model({32'd0, in_a}, {32'd0, in_b}, op_max, 8, 23, r, nv);
        exp_q.push_back({r[31:0], nv, in_tag});
        n_in++;
      end
    end
  end

  // driver tasks
  task automatic send0(input logic [31:0] x, input logic [31:0] y, input logic m, input logic [4:0] t);
    int k;
    in_valid = 1'b1; in_a = x; in_b = y; op_max = m; in_tag = t;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      k++;
      if (k > 50) begin chk("send_timeout", 0, 1); break; end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain0();
    int k;
    out_ready = 1'b1;
    in_valid  = 1'b0;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  task automatic run_one0(input string name, input logic [31:0] x, input logic [31:0] y,
                          input logic m, input logic [4:0] t,
                          input logic [31:0] er, input logic env);
    logic [63:0] r;
    logic nv;
    int k;
    model({32'd0, x}, {32'd0, y}, m, 8, 23, r, nv);
    chk({name, "_model_res"}, r, {32'd0, er});
    chk({name, "_model_nv"}, nv, env);
    out_ready = 1'b1;
    send0(x, y, m, t);
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (out_valid) break;
    end
    chk({name, "_latency"}, k, LAT0);
    chk({name, "_res"}, res, er);
    chk({name, "_nv"}, flag_nv, env);
    chk({name, "_tag"}, out_tag, t);
    @(posedge clk); #1;
  endtask

  task automatic run_one1(input string name, input logic [63:0] x, input logic [63:0] y,
                          input logic m, input logic [4:0] t,
                          input logic has_lit, input logic [63:0] er);
    logic [63:0] r;
    logic nv;
    int k;
    model(x, y, m, 11, 52, r, nv);
    if (has_lit) chk({name, "_model_res"}, r, er);
    d_in_valid = 1'b1; d_a = x; d_b = y; d_op_max = m; d_in_tag = t;
    k = 0;
    while (1) begin
      @(negedge clk);
      if (d_in_ready) break;
      k++;
      if (k > 50) begin chk({name, "_send_timeout"}, 0, 1); break; end
    end
    @(posedge clk); #1;
    d_in_valid = 1'b0;
    for (k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (d_out_valid) break;
    end
    chk({name, "_latency"}, k, LAT1);
    chk({name, "_res"}, d_res, r);
    chk({name, "_nv"}, d_flag_nv, nv);
    chk({name, "_tag"}, d_out_tag, t);
    @(posedge clk); #1;
  endtask

  initial begin
    int n0;
    logic acc;
    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_res", res, 0);
    chk("rst_nv", flag_nv, 0);
    chk("rst_tag", out_tag, 0);
    chk("rst_d_out_valid", d_out_valid, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed single precision
    run_one0("max_pos_neg", 32'h3F800000, 32'hC0000000, 1'b1, 5'd3, 32'h3F800000, 1'b0);
    run_one0("min_zeros",   32'h00000000, 32'h80000000, 1'b0, 5'd4, 32'h80000000, 1'b0);
    run_one0("max_zeros",   32'h00000000, 32'h80000000, 1'b1, 5'd5, 32'h00000000, 1'b0);
    run_one0("min_qnan",    32'h7FC00000, 32'h40400000, 1'b0, 5'd6, 32'h40400000, 1'b0);
    run_one0("max_2nan",    32'h7F800001, 32'h7FC12345, 1'b1, 5'd7, 32'h7FC00000, 1'b1);
    run_one0("min_snan",    32'h7F800001, 32'h3F800000, 1'b0, 5'd8, 32'h3F800000, 1'b1);
    run_one0("min_negs",    32'hBF800000, 32'hC0000000, 1'b0, 5'd9, 32'hC0000000, 1'b0);
    run_one0("max_negs",    32'hBF800000, 32'hC0000000, 1'b1, 5'd10, 32'hBF800000, 1'b0);
    run_one0("max_pos",     32'h3F800000, 32'h40000000, 1'b1, 5'd11, 32'h40000000, 1'b0);

    // back-to-back stream of 16, then a second 16 with a 5-cycle stall mid-stream
    n0 = n_out;
    for (int i = 0; i < 16; i++)
      send0(32'(rand_fp(8, 23)), 32'(rand_fp(8, 23)), 1'($urandom_range(0, 1)), 5'(i));
    drain0();
    chk("stream_count", n_out - n0, 16);
    n0 = n_out;
    for (int i = 0; i < 16; i++) begin
      if (i == 8) begin
        out_ready = 1'b0;
        fork
          begin
            repeat (5) begin
              @(negedge clk);
              chk("stall_in_ready", in_ready, 0);
              chk("stall_out_valid", out_valid, 1);
              @(posedge clk);
            end
            #1 out_ready = 1'b1;
          end
        join_none
      end
      send0(32'(rand_fp(8, 23)), 32'(rand_fp(8, 23)), 1'($urandom_range(0, 1)), 5'(i + 16));
    end
    drain0();
    chk("stall_stream_count", n_out - n0, 16);

    // randomized valid/ready traffic
    in_valid = 1'b0;
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 3) != 0);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_a     = 32'(rand_fp(8, 23));
        in_b     = ($urandom_range(0, 5) == 0) ? in_a : 32'(rand_fp(8, 23));
        op_max   = 1'($urandom_range(0, 1));
        in_tag   = 5'($urandom());
      end
    end
    drain0();
    chk("random_in_out", n_out, n_in);

    // reset with two operations in flight
    out_ready = 1'b1;
    send0(32'h3F800000, 32'h40000000, 1'b1, 5'd1);
    send0(32'h3F800000, 32'h40000000, 1'b0, 5'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_res", res, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_tag", out_tag, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    run_one0("after_rst", 32'hC0400000, 32'h40400000, 1'b0, 5'd12, 32'hC0400000, 1'b0);
    drain0();

    // double precision instance
    run_one1("d_max_negs", 64'hBFF0000000000000, 64'hC000000000000000, 1'b1, 5'd1, 1'b1, 64'hBFF0000000000000);
    run_one1("d_both_nan", 64'h7FF0000000000001, 64'hFFF8000000000000, 1'b0, 5'd2, 1'b1, 64'h7FF8000000000000);
    run_one1("d_min_zero", 64'h0000000000000000, 64'h8000000000000000, 1'b0, 5'd3, 1'b1, 64'h8000000000000000);
    for (int i = 0; i < 30; i++)
      run_one1("d_rand", rand_fp(11, 52), rand_fp(11, 52), 1'($urandom_range(0, 1)), 5'(i), 1'b0, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
